// File: rtl/ddco_pkg.sv
// rtl/ddco_pkg.sv - shared types and constants for the exhaustive pattern generator
package ddco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_PATTERNS = 8;
  localparam int RESP_W     = 16;
  localparam int PAT_W      = $clog2(N_PATTERNS);

  // Counter width for a modulo-n count; a single-state counter still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exhaustive_pattern_gen_if.sv
// rtl/exhaustive_pattern_gen_if.sv - stimulus/capture bus between the generator and the circuit under test
interface exhaustive_pattern_gen_if;

  logic                        start;
  logic                        A;
  logic                        B;
  logic                        C;
  logic                        D;
  logic                        E;
  logic                        busy;
  logic                        done;
  logic [ddco_pkg::PAT_W-1:0]  pat_idx;
  logic [ddco_pkg::RESP_W-1:0] resp;

  modport master (
    input  start, D, E,
    output A, B, C, busy, done, pat_idx, resp
  );

  modport slave (
    output start, D, E,
    input  A, B, C, busy, done, pat_idx, resp
  );

endinterface

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - modulo-TERM up/down counter with a terminal-count flag
module hold_timer #(
  parameter int TERM = 20,
  parameter bit DOWN = 1'b0,
  parameter int W    = ddco_pkg::cnt_width(TERM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST   = W'(TERM - 1);
  localparam logic [W-1:0] FIRST  = DOWN ? LAST : '0;
  localparam logic [W-1:0] TC_VAL = DOWN ? '0 : LAST;

  logic [W-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  // Wraps on terminal count so the count never leaves 0..TERM-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FIRST;
    end else if (clr || tc) begin
      cnt <= FIRST;
    end else if (en) begin
      cnt <= DOWN ? (cnt - 1'b1) : (cnt + 1'b1);
    end
  end

endmodule

// File: rtl/exhaustive_pattern_gen.sv
// rtl/exhaustive_pattern_gen.sv - drives all eight {A,B,C} patterns and captures {D,E} per pattern
module exhaustive_pattern_gen
  import ddco_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input logic                     clk,
  input logic                     rst_n,
  exhaustive_pattern_gen_if.master bus
);

  localparam int               CNT_W    = cnt_width(HOLD_CYCLES);
  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(N_PATTERNS - 1);

  state_t              state;
  logic [PAT_W-1:0]    pat_idx;
  logic [PAT_W-1:0]    abc;
  logic                busy;
  logic                done;
  logic [RESP_W-1:0]   resp;
  logic                window_end;

  hold_timer #(
    .TERM (HOLD_CYCLES),
    .DOWN (1'b0),
    .W    (CNT_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != RUN),
    .en    (state == RUN),
    .tc    (window_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pat_idx <= '0;
      abc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      resp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            busy    <= 1'b1;
            resp    <= '0;
            pat_idx <= '0;
            abc     <= '0;
          end
        end
        RUN: begin
          // Sample on the last cycle of the window to give the circuit maximum settling time.
          if (window_end) begin
            resp[{pat_idx, 1'b0} +: 2] <= {bus.D, bus.E};
            if (pat_idx == LAST_PAT) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pat_idx <= '0;
              abc     <= '0;
            end else begin
              pat_idx <= pat_idx + 1'b1;
              abc     <= pat_idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A       = abc[2];
  assign bus.B       = abc[1];
  assign bus.C       = abc[0];
  assign bus.pat_idx = pat_idx;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.resp    = resp;

endmodule

// File: tb/tb_exhaustive_pattern_gen.sv
// tb/tb_exhaustive_pattern_gen.sv - self-checking bench for exhaustive_pattern_gen
module tb_exhaustive_pattern_gen;
  import ddco_pkg::*;

  typedef struct {
    logic [2:0] abc;
    logic [1:0] de;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  int   errors = 0;
  int   checks = 0;

  vec_t tbl20 [8];
  vec_t tbl1  [8];
  vec_t        exp_pat_q  [$];
  logic [15:0] exp_resp_q [$];

  always #5 clk = ~clk;

  exhaustive_pattern_gen_if bus20 ();
  exhaustive_pattern_gen_if bus1 ();

  exhaustive_pattern_gen #(.HOLD_CYCLES(20)) dut20 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus20)
  );

  exhaustive_pattern_gen #(.HOLD_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Circuit-under-test models.
  assign bus20.D = bus20.A ^ bus20.B;
  assign bus20.E = bus20.C;
  assign bus1.D  = 1'b1;
  assign bus1.E  = 1'b1;

  logic [2:0]  m_abc;
  logic [2:0]  m_idx;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_resp;

  assign m_abc  = sel ? {bus1.A, bus1.B, bus1.C} : {bus20.A, bus20.B, bus20.C};
  assign m_idx  = sel ? bus1.pat_idx : bus20.pat_idx;
  assign m_busy = sel ? bus1.busy : bus20.busy;
  assign m_done = sel ? bus1.done : bus20.done;
  assign m_resp = sel ? bus1.resp : bus20.resp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) bus1.start = v;
    else     bus20.start = v;
  endtask

  function automatic logic [15:0] table_resp(input logic use1);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = use1 ? tbl1[i].de : tbl20[i].de;
    return r;
  endfunction

  task automatic run_sweep(input int h, input logic poke, input int poke_pat);
    vec_t        v;
    logic [1:0]  prev_de;
    logic [15:0] exp_r;
    int          n;
    prev_de = 2'b00;
    for (int i = 0; i < 8; i++) exp_pat_q.push_back(sel ? tbl1[i] : tbl20[i]);
    exp_resp_q.push_back(table_resp(sel));
    @(negedge clk);
    set_start(1'b1);
    n = 0;
    @(negedge clk);
    n++;
    set_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      v = exp_pat_q.pop_front();
      for (int c = 0; c < h; c++) begin
        if (!(i == 0 && c == 0)) begin
          @(negedge clk);
          n++;
        end
        if (c == 0) begin
          check("pat_first", {29'd0, m_abc}, {29'd0, v.abc});
          check("pat_idx", {29'd0, m_idx}, {29'd0, v.abc});
          check("busy_run", {31'd0, m_busy}, 32'd1);
          check("done_run", {31'd0, m_done}, 32'd0);
          if (i > 0) check("capture", {30'd0, m_resp[2*(i-1) +: 2]}, {30'd0, prev_de});
          if (poke && i == poke_pat) set_start(1'b1);
          if (poke && i == poke_pat + 1) set_start(1'b0);
        end
        if (c == h - 1) check("pat_last", {29'd0, m_abc}, {29'd0, v.abc});
      end
      prev_de = v.de;
    end
    @(negedge clk);
    n++;
    exp_r = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 16'hxxxx;
    check("done_pulse", {31'd0, m_done}, 32'd1);
    check("done_latency", n, 8 * h + 1);
    check("done_idle_out", {28'd0, m_busy, m_abc}, 32'd0);
    check("resp_final", {16'd0, m_resp}, {16'd0, exp_r});
    @(negedge clk);
    check("done_single", {31'd0, m_done}, 32'd0);
    check("resp_hold", {16'd0, m_resp}, {16'd0, exp_r});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int low;
    int gap;
    bool_seen: begin end
    tbl20[0] = '{abc: 3'b000, de: 2'b00};
    tbl20[1] = '{abc: 3'b001, de: 2'b01};
    tbl20[2] = '{abc: 3'b010, de: 2'b10};
    tbl20[3] = '{abc: 3'b011, de: 2'b11};
    tbl20[4] = '{abc: 3'b100, de: 2'b10};
    tbl20[5] = '{abc: 3'b101, de: 2'b11};
    tbl20[6] = '{abc: 3'b110, de: 2'b00};
    tbl20[7] = '{abc: 3'b111, de: 2'b01};
    for (int i = 0; i < 8; i++) tbl1[i] = '{abc: 3'(i), de: 2'b11};

    bus20.start = 1'b0;
    bus1.start  = 1'b0;
    repeat (3) @(negedge clk);
    check("in_reset_20", {bus20.A, bus20.B, bus20.C, bus20.busy, bus20.done, bus20.pat_idx, bus20.resp}, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("idle_20", {bus20.A, bus20.B, bus20.C, bus20.busy, bus20.done, bus20.resp}, 0);
      check("idle_1", {bus1.A, bus1.B, bus1.C, bus1.busy, bus1.done, bus1.resp}, 0);
    end

    sel = 1'b0;
    run_sweep(20, 1'b0, 0);
    check("table_4ee4", {16'd0, table_resp(1'b0)}, 32'h4EE4);

    sel = 1'b1;
    run_sweep(1, 1'b0, 0);

    sel = 1'b0;
    run_sweep(20, 1'b1, 3);

    // Reset in the middle of pattern 5.
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    n = 0;
    while (m_idx != 3'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_pat5", {29'd0, m_idx}, 32'd5);
    check("partial_resp_nonzero", {31'd0, (m_resp != 16'h0)}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {m_abc, m_busy, m_done, m_idx, m_resp}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(20, 1'b0, 0);

    // Start held high: back-to-back sweeps.
    begin
      int done_at [$];
      logic seen_busy;
      seen_busy = 1'b0;
      low = 0;
      gap = -1;
      exp_resp_q.push_back(table_resp(1'b0));
      exp_resp_q.push_back(table_resp(1'b0));
      @(negedge clk);
      set_start(1'b1);
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        if (m_busy) begin
          if (low > 0 && gap < 0) gap = low;
          seen_busy = 1'b1;
        end else if (seen_busy) begin
          low++;
        end
        if (m_done) begin
          done_at.push_back(c);
          if (exp_resp_q.size() > 0) check("b2b_resp", {16'd0, m_resp}, {16'd0, exp_resp_q.pop_front()});
          else check("b2b_extra_done", c, 0);
        end
      end
      set_start(1'b0);
      check("b2b_done_count", done_at.size(), 2);
      if (done_at.size() >= 2) begin
        check("b2b_first_done", done_at[0], 161);
        check("b2b_spacing", done_at[1] - done_at[0], 162);
      end
      check("b2b_busy_gap", gap, 2);
      n = 0;
      while (!m_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("b2b_third_done", {31'd0, m_done}, 32'd1);
      @(negedge clk);
      check("b2b_settle_idle", {30'd0, m_busy, m_done}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
